sdf_frame_ctrl: RTL and testbench

//  Frame sequencer in front of the radix-2 SDF FFT stage chain (N=16).
//  - Buffers one N-sample frame from a valid/ready source.
//  - Replays the frame to the first SDF stage as one gap-free input_en burst of N cycles.
//  - Holds input_en low for a flush window so every stage drains.
//  - On the last stage's output: tags samples with a natural-order bin index, marks the

---
 rtl/sdf_frame_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sdf_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_frame_ctrl.sv
// sdf_frame_ctrl
// Frame sequencer wrapped around a radix-2 SDF FFT stage chain.
//  Input side: captures one N-sample frame from a valid/ready source into a
//  buffer. It then replays the frame to the first stage as one gap-free
//  fft_in_en burst of N cycles. After the burst it holds fft_in_en low for
//  FLUSH_CYCLES cycles so the pipeline drains.
//  Output side: registers the last stage's output, tags each sample with its
//  natural-order bin index, marks the last sample of each frame, counts
//  completed frames and flags broken frames.
// Ports
//  clock, reset        master clock (rising edge), asynchronous active-high reset
//  enable              allows a new frame load (sampled in IDLE and at end of flush)
//  s_valid/s_ready     source handshake, s_real/s_imag source sample
//  fft_in_en/_real/_imag   drive to first SDF stage
//  fft_out_en/_real/_imag  from last SDF stage
//  m_valid/m_real/m_imag/m_index/m_last   tagged result stream (no backpressure)
//  busy                FSM not idle
//  frame_err, err_clr  sticky broken-frame flag and its synchronous clear
//  frame_cnt           completed output frames, wraps at 2^16
module sdf_frame_ctrl #(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int LOG2N        = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_real,
    input  logic [WIDTH-1:0] s_imag,
    output logic             fft_in_en,
    output logic [WIDTH-1:0] fft_in_real,
    output logic [WIDTH-1:0] fft_in_imag,
    input  logic             fft_out_en,
    input  logic [WIDTH-1:0] fft_out_real,
    input  logic [WIDTH-1:0] fft_out_imag,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_real,
    output logic [WIDTH-1:0] m_imag,
    output logic [LOG2N-1:0] m_index,
    output logic             m_last,
    output logic             busy,
    output logic             frame_err,
    input  logic             err_clr,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, BURST, FLUSH} state_t;

    localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] IDX_ONE    = LOG2N'(1);
    localparam logic [7:0]       FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    state_t             state_reg;
    logic [LOG2N-1:0]   wr_reg;
    logic [LOG2N-1:0]   rd_reg;
    logic [7:0]         flush_reg;
    logic               s_ready_reg;
    logic               busy_reg;
    logic               fft_in_en_reg;
    logic [WIDTH-1:0]   fft_in_real_reg;
    logic [WIDTH-1:0]   fft_in_imag_reg;

    logic [2*WIDTH-1:0] buf_mem [0:N-1];
    logic [2*WIDTH-1:0] rd_word;
    logic               accept;

    assign accept  = (state_reg == LOAD) && s_ready_reg && s_valid;
    assign rd_word = buf_mem[rd_reg];

    // Frame buffer: written only while loading, never reset (contents are
    // irrelevant until a complete frame has been captured).
    always_ff @(posedge clock) begin
        if (accept) begin
            buf_mem[wr_reg] <= {s_real, s_imag};
        end
    end

    // Input-side sequencer. The burst's first sample is launched on the same
    // edge that takes the Nth accept, so en and data rise together. rd_reg
    // then walks 1..N-1 and wraps to 0, which marks "all N samples issued".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            wr_reg          <= '0;
            rd_reg          <= '0;
            flush_reg       <= '0;
            s_ready_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            fft_in_en_reg   <= 1'b0;
            fft_in_real_reg <= '0;
            fft_in_imag_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg   <= LOAD;
                        s_ready_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (wr_reg == LAST_IDX) begin
                            wr_reg          <= '0;
                            s_ready_reg     <= 1'b0;
                            state_reg       <= BURST;
                            fft_in_en_reg   <= 1'b1;
                            fft_in_real_reg <= rd_word[2*WIDTH-1:WIDTH];
                            fft_in_imag_reg <= rd_word[WIDTH-1:0];
                            rd_reg          <= rd_reg + IDX_ONE;
                        end else begin
                            wr_reg <= wr_reg + IDX_ONE;
                        end
                    end
                end
                BURST: begin
                    if (rd_reg == '0) begin
                        // Data registers keep the last sample through the flush.
                        fft_in_en_reg <= 1'b0;
                        flush_reg     <= '0;
                        state_reg     <= FLUSH;
                    end else begin
                        fft_in_real_reg <= rd_word[2*WIDTH-1:WIDTH];
                        fft_in_imag_reg <= rd_word[WIDTH-1:0];
                        rd_reg          <= rd_reg + IDX_ONE;
                    end
                end
                FLUSH: begin
                    if (flush_reg == FLUSH_LAST) begin
                        if (enable) begin
                            state_reg   <= LOAD;
                            s_ready_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        flush_reg <= flush_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    s_ready_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_reg;
    assign busy        = busy_reg;
    assign fft_in_en   = fft_in_en_reg;
    assign fft_in_real = fft_in_real_reg;
    assign fft_in_imag = fft_in_imag_reg;

    // Output side. SDF output arrives in bit-reversed order, so reversing
    // the position counter gives the natural-order bin.
    logic [LOG2N-1:0] out_cnt_reg;
    logic [LOG2N-1:0] out_cnt_rev;
    logic             err_set;
    logic             m_valid_reg;
    logic [WIDTH-1:0] m_real_reg;
    logic [WIDTH-1:0] m_imag_reg;
    logic [LOG2N-1:0] m_index_reg;
    logic             m_last_reg;
    logic             frame_err_reg;
    logic [15:0]      frame_cnt_reg;

    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign out_cnt_rev[gi] = out_cnt_reg[LOG2N-1-gi];
        end
    endgenerate

    // A gap in fft_out_en part-way through a frame means the frame is broken.
    assign err_set = !fft_out_en && (out_cnt_reg != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_cnt_reg   <= '0;
            m_valid_reg   <= 1'b0;
            m_real_reg    <= '0;
            m_imag_reg    <= '0;
            m_index_reg   <= '0;
            m_last_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            m_valid_reg <= fft_out_en;
            m_real_reg  <= fft_out_real;
            m_imag_reg  <= fft_out_imag;
            m_index_reg <= out_cnt_rev;
            m_last_reg  <= fft_out_en && (out_cnt_reg == LAST_IDX);
            if (fft_out_en) begin
                out_cnt_reg <= out_cnt_reg + IDX_ONE;
                if (out_cnt_reg == LAST_IDX) begin
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
                end
            end else if (err_set) begin
                out_cnt_reg <= '0;
            end
            // A new error takes priority over a simultaneous clear.
            if (err_set) begin
                frame_err_reg <= 1'b1;
            end else if (err_clr) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    assign m_valid   = m_valid_reg;
    assign m_real    = m_real_reg;
    assign m_imag    = m_imag_reg;
    assign m_index   = m_index_reg;
    assign m_last    = m_last_reg;
    assign frame_err = frame_err_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_sdf_frame_ctrl.sv
// Self-checking bench for sdf_frame_ctrl: directed stimulus, a behavioural
// model of both sides checked every cycle, and literal expectations.
module tb_sdf_frame_ctrl;
    localparam int WIDTH = 32;
    localparam int N     = 16;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_real;
    logic [WIDTH-1:0] s_imag;
    logic             fft_in_en;
    logic [WIDTH-1:0] fft_in_real;
    logic [WIDTH-1:0] fft_in_imag;
    logic             fft_out_en;
    logic [WIDTH-1:0] fft_out_real;
    logic [WIDTH-1:0] fft_out_imag;
    logic             m_valid;
    logic [WIDTH-1:0] m_real;
    logic [WIDTH-1:0] m_imag;
    logic [3:0]       m_index;
    logic             m_last;
    logic             busy;
    logic             frame_err;
    logic             err_clr;
    logic [15:0]      frame_cnt;

    sdf_frame_ctrl #(.WIDTH(WIDTH), .N(N), .LOG2N(4), .FLUSH_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
        .fft_in_en(fft_in_en), .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
        .fft_out_en(fft_out_en), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
        .m_valid(m_valid), .m_real(m_real), .m_imag(m_imag), .m_index(m_index),
        .m_last(m_last), .busy(busy), .frame_err(frame_err), .err_clr(err_clr),
        .frame_cnt(frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Natural-order bin of SDF output position p (bit reversal of 4 bits).
    function automatic int bin_of(input int p);
        int r = 0;
        for (int i = 0; i < 4; i++) r = r * 2 + ((p >> i) & 1);
        return r;
    endfunction

    // ---------------- input-side model: burst must replay accepts in order
    logic [63:0] acc_q[$];
    int          run_len = 0;

    always @(negedge clock) begin
        if (reset) begin
            acc_q.delete();
            run_len = 0;
        end else begin
            if (s_valid && s_ready) acc_q.push_back({s_real, s_imag});
            if (fft_in_en) begin
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL burst_underrun: got en=1 with no accepted sample pending, required en=0");
                end else begin
                    check("burst_data", {fft_in_real, fft_in_imag}, acc_q.pop_front());
                end
                run_len++;
            end else if (run_len != 0) begin
                check("burst_len", run_len, N);
                run_len = 0;
            end
        end
    end

    // ---------------- output-side model: position/frame bookkeeping
    int          pos = 0, frames = 0;
    bit          err = 0;
    bit          exp_mv = 0, exp_last = 0;
    int          exp_idx = 0;
    logic [31:0] exp_re = 0, exp_im = 0;

    always @(negedge clock) begin
        if (reset) begin
            pos = 0; frames = 0; err = 0;
            exp_mv = 0; exp_last = 0; exp_idx = 0; exp_re = 0; exp_im = 0;
        end else begin
            check("m_valid", m_valid, exp_mv);
            if (exp_mv) begin
                check("m_index", m_index, exp_idx);
                check("m_last", m_last, exp_last);
                check("m_real", m_real, exp_re);
                check("m_imag", m_imag, exp_im);
            end
            check("frame_cnt", frame_cnt, frames);
            check("frame_err", frame_err, err);
            // Predict what the next edge registers.
            exp_mv = fft_out_en;
            exp_re = fft_out_real;
            exp_im = fft_out_imag;
            exp_idx = bin_of(pos);
            exp_last = fft_out_en && (pos == N - 1);
            if (fft_out_en) begin
                pos = (pos + 1) % N;
                if (pos == 0) frames = (frames + 1) % 65536;
                if (err_clr) err = 0;
            end else if (pos != 0) begin
                pos = 0;
                err = 1;
            end else if (err_clr) begin
                err = 0;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic send_frame(input int base, input int imul, input bit stall, output bit en_seen);
        int k = 0;
        int cyc = 0;
        bit acc;
        en_seen = 0;
        @(posedge clock); #1;
        while (k < N && cyc < 400) begin
            s_valid = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            s_real  = 32'(base + k + 1);
            s_imag  = 32'(k * imul);
            @(negedge clock);
            acc = s_valid && s_ready;
            if (fft_in_en) en_seen = 1;
            @(posedge clock); #1;
            if (acc) k++;
            cyc++;
        end
        s_valid = 1'b0;
        if (k < N) begin
            total++;
            bad++;
            $display("FAIL load_timeout: got %0d accepts, required %0d", k, N);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_fft_in_en"}, fft_in_en, 0);
        check({tag, "_fft_in_real"}, fft_in_real, 0);
        check({tag, "_fft_in_imag"}, fft_in_imag, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_real"}, m_real, 0);
        check({tag, "_m_index"}, m_index, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    logic [3:0] idx_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    initial begin
        bit en_seen;
        int n;
        reset = 1; enable = 0; s_valid = 0; s_real = 0; s_imag = 0;
        fft_out_en = 0; fft_out_real = 0; fft_out_imag = 0; err_clr = 0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 0;

        // 1: straight frame, samples (k+1, 0)
        enable = 1;
        send_frame(0, 0, 0, en_seen);
        check("t1_no_early_en", en_seen, 0);
        @(negedge clock);
        check("t1_s_ready_drop", s_ready, 0);
        check("t1_first_en", fft_in_en, 1);
        check("t1_first_real", fft_in_real, 1);
        check("t1_busy", busy, 1);
        n = 0;
        while (fft_in_en && n < 40) begin n++; @(negedge clock); end
        check("t1_burst_cycles", n, 16);
        check("t1_hold_real", fft_in_real, 16);
        n = 0;
        while (!fft_in_en && !s_ready && n < 40) begin n++; @(negedge clock); end
        check("t1_flush_cycles", n, 16);

        // 2: stalling source 1,0,0,1,...
        send_frame(100, 7, 1, en_seen);
        check("t2_no_early_en", en_seen, 0);
        @(negedge clock);
        check("t2_first_en", fft_in_en, 1);
        check("t2_first_real", fft_in_real, 101);
        n = 0;
        while (fft_in_en && n < 40) begin n++; @(negedge clock); end
        check("t2_burst_cycles", n, 16);
        check("t2_hold_imag", fft_in_imag, 105);
        n = 0;
        while (!fft_in_en && !s_ready && n < 40) begin n++; @(negedge clock); end
        check("t2_flush_cycles", n, 16);

        // 5: enable dropped during burst
        send_frame(200, 3, 0, en_seen);
        enable = 0;
        @(negedge clock);
        check("t5_busy_burst", busy, 1);
        n = 0;
        while (fft_in_en && n < 40) begin n++; @(negedge clock); end
        check("t5_burst_cycles", n, 16);
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clock); end
        check("t5_flush_cycles", n, 16);
        repeat (4) @(negedge clock);
        check("t5_busy_idle", busy, 0);
        check("t5_s_ready_idle", s_ready, 0);
        check("t5_en_idle", fft_in_en, 0);

        // 3: two back-to-back output frames
        @(posedge clock); #1;
        for (int j = 0; j < 32; j++) begin
            fft_out_en = 1;
            fft_out_real = 32'(j + 500);
            fft_out_imag = 32'(j * 3);
            @(posedge clock); #1;
            check("t3_m_valid", m_valid, 1);
            check("t3_m_index", m_index, idx_tab[j % 16]);
            check("t3_m_last", m_last, (j % 16) == 15);
            check("t3_m_real", m_real, j + 500);
            if (j == 15) check("t3_frame_cnt_1", frame_cnt, 1);
        end
        fft_out_en = 0;
        check("t3_frame_cnt_2", frame_cnt, 2);
        check("t3_no_err", frame_err, 0);

        // 4: broken frame, recovery, clear, set-vs-clear priority
        for (int j = 0; j < 5; j++) begin
            fft_out_en = 1;
            @(posedge clock); #1;
        end
        fft_out_en = 0;
        @(posedge clock); #1;
        check("t4_err_set", frame_err, 1);
        check("t4_cnt_kept", frame_cnt, 2);
        for (int j = 0; j < 16; j++) begin
            fft_out_en = 1;
            @(posedge clock); #1;
            check("t4_restart_index", m_index, idx_tab[j]);
            check("t4_restart_last", m_last, j == 15);
        end
        fft_out_en = 0;
        check("t4_frame_cnt_3", frame_cnt, 3);
        check("t4_err_sticky", frame_err, 1);
        err_clr = 1;
        @(posedge clock); #1;
        err_clr = 0;
        check("t4_err_cleared", frame_err, 0);
        for (int j = 0; j < 3; j++) begin
            fft_out_en = 1;
            @(posedge clock); #1;
        end
        fft_out_en = 0;
        err_clr = 1;
        @(posedge clock); #1;
        err_clr = 0;
        check("t4_set_beats_clr", frame_err, 1);
        err_clr = 1;
        @(posedge clock); #1;
        err_clr = 0;
        check("t4_err_cleared2", frame_err, 0);

        // 6: reset in burst cycle 7, then a full new frame is required
        enable = 1;
        send_frame(300, 1, 0, en_seen);
        repeat (6) @(posedge clock);
        #1;
        check("t6_in_burst", fft_in_en, 1);
        reset = 1;
        #1;
        check_all_zero("t6_reset");
        @(posedge clock); #1;
        reset = 0;
        send_frame(400, 2, 0, en_seen);
        check("t6_no_early_en", en_seen, 0);
        @(negedge clock);
        check("t6_first_en", fft_in_en, 1);
        check("t6_first_real", fft_in_real, 401);
        enable = 0;
        n = 0;
        while (fft_in_en && n < 40) begin n++; @(negedge clock); end
        check("t6_burst_cycles", n, 16);
        repeat (20) @(negedge clock);
        check("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
